car_lane: RTL and testbench

- Parametrised successor to the single-car mover.
- Drives NUM_CARS cars sharing one lane of GRID_W columns, all moving in a fixed direction.
- Step period is derived from the game level, with saturating arithmetic.
- Adds run/pause/restart control, a registered lane occupancy bitmap, and a registered hit flag for a queried column (the frog position). Sits between the level counter and the collision/render logic.

---
 rtl/car_pkg.sv | 39 +++
 rtl/car_step_timer.sv | 62 ++++++
 rtl/car_lane.sv | 179 +++++++++++++++++
 tb/tb_car_lane.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// car_pkg: shared definitions for the car lanes.
// Holds the direction codes, the lane state encoding, the default lane geometry,
// and the saturating level-to-period function used by the lanes and the timer.
package car_pkg;

  localparam bit DIR_RIGHT = 1'b1;
  localparam bit DIR_LEFT  = 1'b0;

  localparam int unsigned DEF_GRID_W = 20;
  localparam int unsigned DEF_X_W    = 5;
  localparam int unsigned PERIOD_W   = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } lane_state_e;

  // period = max(min_p, base - (L-1)*step), L = max(level,1).
  // The product is formed in 64 bits, so the subtraction saturates at zero
  // instead of wrapping for very high levels.
  function automatic logic [31:0] calc_period(input logic [31:0] level,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] min_p);
    logic [31:0] lvl;
    logic [63:0] prod;
    logic [31:0] diff;
    lvl  = (level == 32'd0) ? 32'd1 : level;
    prod = 64'(lvl - 32'd1) * 64'(step);
    if (prod >= 64'(base)) begin
      diff = 32'd0;
    end else begin
      diff = base - prod[31:0];
    end
    return (diff < min_p) ? min_p : diff;
  endfunction

endpackage

// File: rtl/car_step_timer.sv
// car_step_timer: step countdown for a car lane.
// Converts the level into a (saturated) period, latches it on every reload and
// counts down with hold. The counter reloads on i_Load (entry to RUN) and on
// each expiry; a level change therefore only affects the next period.
// Ports:
//   i_Clk, i_Rst   clock, asynchronous active-high reset
//   i_Clear        reinitialise counter to the level-1 period (restart)
//   i_Load         reload counter from the current level
//   i_Count        decrement enable; expiry only possible while counting
//   i_Level        current level (0 treated as 1)
//   o_Expire_c     combinational strobe: counter is 0 on a counting cycle
//   o_Period       period latched at the last reload
module car_step_timer
  import car_pkg::*;
#(
  parameter int unsigned           LEVEL_W     = 7,
  parameter logic [PERIOD_W-1:0]   BASE_PERIOD = 25'd1000,
  parameter logic [PERIOD_W-1:0]   PERIOD_STEP = 25'd50,
  parameter logic [PERIOD_W-1:0]   MIN_PERIOD  = 25'd100
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Clear,
  input  logic                i_Load,
  input  logic                i_Count,
  input  logic [LEVEL_W-1:0]  i_Level,
  output logic                o_Expire_c,
  output logic [PERIOD_W-1:0] o_Period
);

  if (MIN_PERIOD < 2) begin : g_bad_min_period
    $error("car_step_timer: MIN_PERIOD must be >= 2");
  end

  localparam logic [PERIOD_W-1:0] PERIOD_L1 =
    PERIOD_W'(calc_period(32'd1, 32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(MIN_PERIOD)));

  logic [PERIOD_W-1:0] level_period;
  logic [PERIOD_W-1:0] cnt_q;

  assign level_period =
    PERIOD_W'(calc_period(32'(i_Level), 32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(MIN_PERIOD)));

  assign o_Expire_c = i_Count && (cnt_q == '0);

  // Countdown: clear beats load/expiry reload, which beats plain decrement
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q    <= PERIOD_L1 - PERIOD_W'(1);
      o_Period <= PERIOD_L1;
    end else if (i_Clear) begin
      cnt_q    <= PERIOD_L1 - PERIOD_W'(1);
      o_Period <= PERIOD_L1;
    end else if (i_Load || o_Expire_c) begin
      cnt_q    <= level_period - PERIOD_W'(1);
      o_Period <= level_period;
    end else if (i_Count) begin
      cnt_q    <= cnt_q - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/car_lane.sv
// car_lane: NUM_CARS cars sharing one lane of GRID_W columns.
// All cars step together in DIRECTION once per level-derived period while
// running; run/pause/restart control; registered occupancy bitmap and a
// registered hit flag for the queried column.
// Ports:
//   i_Clk, i_Rst  clock, asynchronous active-high reset
//   i_Run         1 = cars move, 0 = freeze
//   i_Restart     one-cycle request: reposition cars, return to IDLE
//   i_Level       current level (0 treated as 1)
//   i_Query_X     column tested for a hit
//   o_Car_X       packed positions, car k at [k*X_W +: X_W]
//   o_Occupancy   bit c set iff a car is at column c
//   o_Hit         o_Occupancy (post-update) at the previous cycle's i_Query_X
//   o_Step        one-cycle pulse following each position change
module car_lane
  import car_pkg::*;
#(
  parameter int unsigned         GRID_W      = DEF_GRID_W,
  parameter int unsigned         X_W         = DEF_X_W,
  parameter int unsigned         NUM_CARS    = 3,
  parameter int unsigned         INIT_X      = 0,
  parameter int unsigned         CAR_SPACING = 7,
  parameter bit                  DIRECTION   = DIR_RIGHT,
  parameter int unsigned         LEVEL_W     = 7,
  parameter logic [PERIOD_W-1:0] BASE_PERIOD = 25'd1000,
  parameter logic [PERIOD_W-1:0] PERIOD_STEP = 25'd50,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 25'd100
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Run,
  input  logic                       i_Restart,
  input  logic [LEVEL_W-1:0]         i_Level,
  input  logic [X_W-1:0]             i_Query_X,
  output logic [NUM_CARS*X_W-1:0]    o_Car_X,
  output logic [GRID_W-1:0]          o_Occupancy,
  output logic                       o_Hit,
  output logic                       o_Step
);

  localparam int unsigned CARS_W = NUM_CARS * X_W;

  // Elaboration-time parameter sanity
  if ((2 ** X_W) < GRID_W) begin : g_bad_x_w
    $error("car_lane: X_W too narrow for GRID_W");
  end
  if (NUM_CARS < 1) begin : g_bad_num_cars
    $error("car_lane: NUM_CARS must be >= 1");
  end
  if (CAR_SPACING < 1) begin : g_bad_spacing_min
    $error("car_lane: CAR_SPACING must be >= 1");
  end
  if ((NUM_CARS * CAR_SPACING) > GRID_W) begin : g_bad_spacing_fit
    $error("car_lane: NUM_CARS*CAR_SPACING exceeds GRID_W");
  end

  function automatic logic [CARS_W-1:0] init_cars();
    logic [CARS_W-1:0] res;
    res = '0;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      res[k*X_W +: X_W] = X_W'((INIT_X + k * CAR_SPACING) % GRID_W);
    end
    return res;
  endfunction

  function automatic logic [GRID_W-1:0] occ_of(input logic [CARS_W-1:0] cars);
    logic [GRID_W-1:0] occ;
    occ = '0;
    for (int unsigned c = 0; c < GRID_W; c++) begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        if (cars[k*X_W +: X_W] == X_W'(c)) begin
          occ[c] = 1'b1;
        end
      end
    end
    return occ;
  endfunction

  // One column in DIRECTION with wrap at the lane edges
  function automatic logic [CARS_W-1:0] step_cars(input logic [CARS_W-1:0] cars);
    logic [CARS_W-1:0] res;
    logic [X_W-1:0]    x;
    res = '0;
    for (int unsigned k = 0; k < NUM_CARS; k++) begin
      x = cars[k*X_W +: X_W];
      if (DIRECTION == DIR_RIGHT) begin
        x = (x == X_W'(GRID_W - 1)) ? '0 : x + X_W'(1);
      end else begin
        x = (x == '0) ? X_W'(GRID_W - 1) : x - X_W'(1);
      end
      res[k*X_W +: X_W] = x;
    end
    return res;
  endfunction

  localparam logic [CARS_W-1:0] CAR_INIT = init_cars();
  localparam logic [GRID_W-1:0] OCC_INIT = occ_of(CAR_INIT);

  lane_state_e         state_q;
  logic                run_go_c;
  logic                load_c;
  logic                count_c;
  logic                expire_c;
  logic [PERIOD_W-1:0] period_q;
  logic [CARS_W-1:0]   car_next;
  logic [GRID_W-1:0]   occ_next;
  logic                hit_next;

  // Restart outranks run; the timer only loads/counts when not restarting
  assign run_go_c = i_Run && !i_Restart;
  assign load_c   = run_go_c && (state_q == IDLE);
  assign count_c  = run_go_c && (state_q != IDLE);

  car_step_timer #(
    .LEVEL_W     (LEVEL_W),
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clear    (i_Restart),
    .i_Load     (load_c),
    .i_Count    (count_c),
    .i_Level    (i_Level),
    .o_Expire_c (expire_c),
    .o_Period   (period_q)
  );

  // Next positions, occupancy and hit; occupancy/hit see the post-step lane
  always_comb begin
    car_next = o_Car_X;
    if (i_Restart) begin
      car_next = CAR_INIT;
    end else if (expire_c) begin
      car_next = step_cars(o_Car_X);
    end
    occ_next = occ_of(car_next);
    hit_next = 1'b0;
    for (int unsigned c = 0; c < GRID_W; c++) begin
      if (i_Query_X == X_W'(c)) begin
        hit_next = occ_next[c];
      end
    end
  end

  // Lane FSM and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      o_Car_X     <= CAR_INIT;
      o_Occupancy <= OCC_INIT;
      o_Hit       <= 1'b0;
      o_Step      <= 1'b0;
    end else begin
      o_Car_X     <= car_next;
      o_Occupancy <= occ_next;
      o_Hit       <= hit_next;
      o_Step      <= expire_c;
      if (i_Restart) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    if (i_Run)  state_q <= RUN;
          RUN:     if (!i_Run) state_q <= PAUSE;
          PAUSE:   if (i_Run)  state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The latched period can never drop below the floor
  property p_period_floor;
    @(posedge i_Clk) disable iff (i_Rst) period_q >= MIN_PERIOD;
  endproperty
  a_period_floor: assert property (p_period_floor);

endmodule

// File: tb/tb_car_lane.sv
// tb_car_lane: directed, table-driven bench for car_lane.
// Two instances (rightward and leftward) of an 8-column lane with two cars.
module tb_car_lane;
  import car_pkg::*;

  localparam int unsigned GW = 8;
  localparam int unsigned XW = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned LW = 7;

  logic i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic              rst;
  logic              run, restart;
  logic [LW-1:0]     level;
  logic [XW-1:0]     qx;
  logic [NC*XW-1:0]  car_x;
  logic [GW-1:0]     occ;
  logic              hit, step;

  logic              run_l, restart_l;
  logic [LW-1:0]     level_l;
  logic [XW-1:0]     qx_l;
  logic [NC*XW-1:0]  car_x_l;
  logic [GW-1:0]     occ_l;
  logic              hit_l, step_l;

  car_lane #(
    .GRID_W(GW), .X_W(XW), .NUM_CARS(NC), .INIT_X(1), .CAR_SPACING(4),
    .DIRECTION(DIR_RIGHT), .LEVEL_W(LW),
    .BASE_PERIOD(25'd10), .PERIOD_STEP(25'd2), .MIN_PERIOD(25'd4)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(rst), .i_Run(run), .i_Restart(restart),
    .i_Level(level), .i_Query_X(qx),
    .o_Car_X(car_x), .o_Occupancy(occ), .o_Hit(hit), .o_Step(step)
  );

  car_lane #(
    .GRID_W(GW), .X_W(XW), .NUM_CARS(NC), .INIT_X(1), .CAR_SPACING(4),
    .DIRECTION(DIR_LEFT), .LEVEL_W(LW),
    .BASE_PERIOD(25'd10), .PERIOD_STEP(25'd2), .MIN_PERIOD(25'd4)
  ) dut_l (
    .i_Clk(i_Clk), .i_Rst(rst), .i_Run(run_l), .i_Restart(restart_l),
    .i_Level(level_l), .i_Query_X(qx_l),
    .o_Car_X(car_x_l), .o_Occupancy(occ_l), .o_Hit(hit_l), .o_Step(step_l)
  );

  typedef struct {
    logic [LW-1:0] lvl;
    int            exp_period;
  } vec_t;

  vec_t vecs [6];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Cycles until o_Step is seen (bounded)
  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < 100);
  endtask

  task automatic wait_step_l(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_l && n < 100);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    run     = 1'b0;
    tick();
    restart = 1'b0;
  endtask

  int  n;
  bit  step_seen;

  initial begin
    vecs[0] = '{lvl: 7'd1,   exp_period: 10};
    vecs[1] = '{lvl: 7'd0,   exp_period: 10};
    vecs[2] = '{lvl: 7'd3,   exp_period: 6};
    vecs[3] = '{lvl: 7'd4,   exp_period: 4};
    vecs[4] = '{lvl: 7'd5,   exp_period: 4};
    vecs[5] = '{lvl: 7'd100, exp_period: 4};

    rst = 1'b1; run = 1'b0; restart = 1'b0; level = 7'd1; qx = 4'd0;
    run_l = 1'b0; restart_l = 1'b0; level_l = 7'd1; qx_l = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset_car_x", 32'(car_x), 32'h51);
    check("reset_occ",   32'(occ),   32'b0010_0010);
    check("reset_hit",   32'(hit),   32'd0);
    check("reset_step",  32'(step),  32'd0);
    qx = 4'd5;
    tick();
    check("idle_hit_col5", 32'(hit), 32'd1);

    // Level 1: three steps, the last one wraps car 1
    level = 7'd1;
    run   = 1'b1;
    tick();
    wait_step(n);
    check("l1_first_step_cycles", 32'(n), 32'd10);
    check("l1_step1_car_x", 32'(car_x), 32'h62);
    check("l1_step1_occ",   32'(occ),   32'b0100_0100);
    tick();
    check("l1_step_pulse_width", 32'(step), 32'd0);
    wait_step(n);
    check("l1_second_step_cycles", 32'(n), 32'd9);
    check("l1_step2_car_x", 32'(car_x), 32'h73);
    wait_step(n);
    check("l1_third_step_cycles", 32'(n), 32'd10);
    check("l1_wrap_car_x", 32'(car_x), 32'h04);
    check("l1_wrap_occ",   32'(occ),   32'b0001_0001);

    // Asynchronous reset mid-cycle, while o_Step is high
    #3 rst = 1'b1;
    #1;
    check("async_rst_car_x", 32'(car_x), 32'h51);
    check("async_rst_occ",   32'(occ),   32'b0010_0010);
    check("async_rst_step",  32'(step),  32'd0);
    check("async_rst_hit",   32'(hit),   32'd0);
    run = 1'b0;
    #2 rst = 1'b0;
    tick();

    // Level-to-period table
    for (int i = 0; i < 6; i++) begin
      do_restart();
      check($sformatf("tbl%0d_restart_car_x", i), 32'(car_x), 32'h51);
      level = vecs[i].lvl;
      run   = 1'b1;
      tick();
      wait_step(n);
      check($sformatf("tbl%0d_lvl%0d_period", i, vecs[i].lvl), 32'(n), 32'(vecs[i].exp_period));
      check($sformatf("tbl%0d_car_x", i), 32'(car_x), 32'h62);
      run = 1'b0;
    end

    // Level change mid-period takes effect from the next step
    do_restart();
    level = 7'd1;
    run   = 1'b1;
    tick();
    repeat (3) tick();
    level = 7'd3;
    wait_step(n);
    check("lvlchg_current_period_rest", 32'(n), 32'd7);
    wait_step(n);
    check("lvlchg_next_period", 32'(n), 32'd6);
    check("lvlchg_car_x", 32'(car_x), 32'h73);

    // Pause for 25 cycles mid-period, then resume the remaining count
    do_restart();
    level = 7'd1;
    run   = 1'b1;
    tick();
    repeat (4) tick();
    run = 1'b0;
    step_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (step) step_seen = 1'b1;
    end
    check("pause_no_step",  32'(step_seen), 32'd0);
    check("pause_frozen",   32'(car_x),     32'h51);
    run = 1'b1;
    wait_step(n);
    check("pause_resume_rest", 32'(n), 32'd6);
    check("pause_resume_car_x", 32'(car_x), 32'h62);

    // Restart with i_Run held high: back to IDLE, then RUN again
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_car_x", 32'(car_x), 32'h51);
    check("restart_occ",   32'(occ),   32'b0010_0010);
    check("restart_step",  32'(step),  32'd0);
    wait_step(n);
    check("restart_rerun_cycles", 32'(n), 32'd11);
    check("restart_rerun_car_x", 32'(car_x), 32'h62);
    run = 1'b0;

    // Leftward lane: hit on column 0, out-of-lane query, wrap 0 -> 7
    qx_l = 4'd0;
    tick();
    check("left_init_hit", 32'(hit_l), 32'd0);
    run_l = 1'b1;
    tick();
    wait_step_l(n);
    check("left_first_step_cycles", 32'(n), 32'd10);
    check("left_step1_car_x", 32'(car_x_l), 32'h40);
    check("left_step1_occ",   32'(occ_l),   32'b0001_0001);
    check("left_hit_col0",    32'(hit_l),   32'd1);
    qx_l = 4'd9;
    tick();
    check("left_hit_col9", 32'(hit_l), 32'd0);
    wait_step_l(n);
    check("left_second_step_cycles", 32'(n), 32'd9);
    check("left_wrap_car_x", 32'(car_x_l), 32'h37);
    check("left_wrap_occ",   32'(occ_l),   32'b1000_1000);
    check("left_hit_q9_at_step", 32'(hit_l), 32'd0);
    qx_l = 4'd7;
    tick();
    check("left_hit_col7", 32'(hit_l), 32'd1);
    run_l = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
